fifo_wr_ingress: RTL

//  Write-domain front end of the async FIFO. It sits directly upstream of fifo_write and the dual-port RAM write port.
//  - Accepts a valid/ready stream and buffers it in a 2-entry skid buffer.
//  - Drives wr_en/wr_data into the FIFO.
//  - Synchronizes the read-domain gray pointer into wr_clk (feeds fifo_write).
//  - Produces a registered write-side fill level and almost_full flag.

---
 rtl/fifo_wr_ingress_pkg.sv | 31 +++
 rtl/fifo_wr_ingress_if.sv | 30 +++
 rtl/fifo_wr_ingress_gry_sync.sv | 33 +++
 rtl/fifo_wr_ingress.sv | 100 ++++++++++
 4 files changed

// File: rtl/fifo_wr_ingress_pkg.sv
// Shared types and helpers for the async FIFO write side: skid states and
// gray/binary pointer conversion.
package fifo_pkg;

   localparam int ADD_WIDTH_DEF = 3;
   localparam int DEPTH         = 2 ** ADD_WIDTH_DEF;

   // Wide enough for any pointer width; callers zero-extend and truncate.
   localparam int GRY_MAX_W = 32;
   typedef logic [GRY_MAX_W-1:0] gry_word_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   function automatic gry_word_t bin2gry(input gry_word_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic gry_word_t gray2bin(input gry_word_t g);
      gry_word_t b;
      b[GRY_MAX_W-1] = g[GRY_MAX_W-1];
      for (int i = GRY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wr_ingress_if.sv
// Stream, pointer and status bundle between the write-side environment and
// fifo_wr_ingress.
interface fifo_wr_ingress_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADD_WIDTH  = ADD_WIDTH_DEF
);
   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;
   logic [ADD_WIDTH:0]    rd_ptr_gry;
   logic [ADD_WIDTH:0]    rd_gry_sync;
   logic [ADD_WIDTH:0]    wr_ptr_bin_gry;
   logic                  fifo_full;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [ADD_WIDTH:0]    wr_level;
   logic                  almost_full;

   modport master (
      output s_valid, s_data, rd_ptr_gry, wr_ptr_bin_gry, fifo_full,
      input  s_ready, rd_gry_sync, wr_en, wr_data, wr_level, almost_full
   );

   modport slave (
      input  s_valid, s_data, rd_ptr_gry, wr_ptr_bin_gry, fifo_full,
      output s_ready, rd_gry_sync, wr_en, wr_data, wr_level, almost_full
   );
endinterface

// File: rtl/fifo_wr_ingress_gry_sync.sv
// N-stage flop synchronizer for a gray-coded pointer; no logic between stages.
module fifo_gry_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_sync     [STAGES];
   logic [WIDTH-1:0] w_stage_in [STAGES];

   assign w_stage_in[0] = i_d;

   generate
      for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
         assign w_stage_in[gi] = r_sync[gi-1];
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync <= w_stage_in;
      end
   end

   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/fifo_wr_ingress.sv
// Write-domain front end of the async FIFO: 2-entry skid buffer feeding the RAM
// write port, rd-pointer synchronizer, and registered fill level / almost_full.
module fifo_wr_ingress
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ADD_WIDTH   = ADD_WIDTH_DEF,
   parameter int AF_THRESH   = 6,
   parameter int SYNC_STAGES = 2
) (
   input logic              wr_clk,
   input logic              wr_rst,
   fifo_wr_ingress_if.slave bus
);
   localparam int PTR_W = ADD_WIDTH + 1;
   localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);

   skid_state_t           r_state;
   logic [DATA_WIDTH-1:0] r_main;
   logic [DATA_WIDTH-1:0] r_skid;
   logic [PTR_W-1:0]      r_level;
   logic                  r_af;

   logic                  w_accept;
   logic                  w_pop;
   logic [PTR_W-1:0]      w_wr_bin;
   logic [PTR_W-1:0]      w_rd_bin;
   logic [PTR_W-1:0]      w_level_next;

   // Handshake outputs come from the state register only, so fifo_full never
   // reaches s_ready combinationally.
   assign bus.s_ready = (r_state != TWO);
   assign bus.wr_en   = (r_state != EMPTY);
   assign bus.wr_data = r_main;

   assign w_accept = bus.s_valid & bus.s_ready;
   assign w_pop    = bus.wr_en & ~bus.fifo_full;

   always_ff @(posedge wr_clk or negedge wr_rst) begin
      if (!wr_rst) begin
         r_state <= EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_state <= ONE;
                  r_main  <= bus.s_data;
               end
            end
            ONE: begin
               if (w_accept && w_pop) begin
                  r_main <= bus.s_data;
               end else if (w_accept) begin
                  r_state <= TWO;
                  r_skid  <= bus.s_data;
               end else if (w_pop) begin
                  r_state <= EMPTY;
               end
            end
            TWO: begin
               if (w_pop) begin
                  r_state <= ONE;
                  r_main  <= r_skid;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

   fifo_gry_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_rd_sync (
      .i_clk   (wr_clk),
      .i_rst_n (wr_rst),
      .i_d     (bus.rd_ptr_gry),
      .o_q     (bus.rd_gry_sync)
   );

   // Modulo subtraction on ADD_WIDTH+1 bits absorbs pointer wrap-around.
   assign w_wr_bin     = PTR_W'(gray2bin(gry_word_t'(bus.wr_ptr_bin_gry)));
   assign w_rd_bin     = PTR_W'(gray2bin(gry_word_t'(bus.rd_gry_sync)));
   assign w_level_next = w_wr_bin - w_rd_bin;

   always_ff @(posedge wr_clk or negedge wr_rst) begin
      if (!wr_rst) begin
         r_level <= '0;
         r_af    <= 1'b0;
      end else begin
         r_level <= w_level_next;
         r_af    <= (w_level_next >= AF_LVL);
      end
   end

   assign bus.wr_level    = r_level;
   assign bus.almost_full = r_af;
endmodule
